// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - NBITS x NBITS product sequenced over one shared WBITS x WBITS digit multiplier
module mult_seq #(
    parameter int NBITS   = 2048,
    parameter int WBITS   = 64,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NBITS-1:0]     a,
    input  logic [NBITS-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*NBITS-1:0]   y,
    output logic                 mul_en,
    output logic [WBITS-1:0]     mul_a,
    output logic [WBITS-1:0]     mul_b,
    input  logic [2*WBITS-1:0]   mul_p
);

    localparam int K  = NBITS / WBITS;
    localparam int KK = K * K;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = (K > 1) ? $clog2(2 * K - 1) : 1;
    localparam int MW = (KK > 1) ? $clog2(KK) : 1;
    localparam int PW = 2 * NBITS;

    generate
        if (NBITS % WBITS != 0) begin : g_bad_width
            $error("mult_seq: NBITS must be an integer multiple of WBITS");
        end
        if (MUL_LAT < 0 || MUL_LAT > 8) begin : g_bad_lat
            $error("mult_seq: MUL_LAT must lie in 0..8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state;
    logic [NBITS-1:0] a_r;
    logic [NBITS-1:0] b_r;
    logic [PW-1:0]   acc;
    logic [KW-1:0]   i_r;
    logic [KW-1:0]   j_r;
    logic [TW-1:0]   tag_r;   // i+j of the digit pair currently on mul_a/mul_b
    logic [MW-1:0]   m_r;     // number of products accumulated so far

    logic            last_issue;
    logic            last_acc;
    logic [KW-1:0]   i_nxt;
    logic [KW-1:0]   j_nxt;
    logic            acc_v;
    logic [TW-1:0]   acc_t;
    logic [PW-1:0]   acc_sum;

    assign last_issue = (i_r == KW'(K - 1)) && (j_r == KW'(K - 1));
    assign last_acc   = (m_r == MW'(KK - 1));
    assign i_nxt      = (j_r == KW'(K - 1)) ? i_r + KW'(1) : i_r;
    assign j_nxt      = (j_r == KW'(K - 1)) ? '0 : j_r + KW'(1);
    assign acc_sum    = acc + (PW'(mul_p) << (WBITS * int'(acc_t)));

    generate
        if (MUL_LAT == 0) begin : g_comb
            assign acc_v = mul_en;
            assign acc_t = tag_r;
        end else begin : g_pipe
            logic [MUL_LAT-1:0] vpipe;
            logic [TW-1:0]      tpipe [MUL_LAT];

            // carry issue-valid and digit offset alongside the multiplier's latency
            always_ff @(posedge clk) begin
                if (rst) begin
                    vpipe <= '0;
                    for (int k = 0; k < MUL_LAT; k++) tpipe[k] <= '0;
                end else begin
                    vpipe[0] <= mul_en;
                    tpipe[0] <= tag_r;
                    for (int k = 1; k < MUL_LAT; k++) begin
                        vpipe[k] <= vpipe[k-1];
                        tpipe[k] <= tpipe[k-1];
                    end
                end
            end

            assign acc_v = vpipe[MUL_LAT-1];
            assign acc_t = tpipe[MUL_LAT-1];
        end
    endgenerate

    // control FSM: accept, issue digit pairs i-outer/j-inner, accumulate, publish
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            i_r    <= '0;
            j_r    <= '0;
            tag_r  <= '0;
            m_r    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            y      <= '0;
            mul_en <= 1'b0;
            mul_a  <= '0;
            mul_b  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        acc    <= '0;
                        i_r    <= '0;
                        j_r    <= '0;
                        m_r    <= '0;
                        tag_r  <= '0;
                        mul_en <= 1'b1;
                        mul_a  <= a[WBITS-1:0];
                        mul_b  <= b[WBITS-1:0];
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE, DRAIN: begin
                    if (state == ISSUE) begin
                        if (last_issue) begin
                            mul_en <= 1'b0;
                            mul_a  <= '0;
                            mul_b  <= '0;
                            tag_r  <= '0;
                            state  <= DRAIN;
                        end else begin
                            i_r   <= i_nxt;
                            j_r   <= j_nxt;
                            mul_a <= a_r[int'(i_nxt) * WBITS +: WBITS];
                            mul_b <= b_r[int'(j_nxt) * WBITS +: WBITS];
                            tag_r <= TW'(i_nxt) + TW'(j_nxt);
                        end
                    end
                    // with zero latency the last product lands on the last issue edge,
                    // so this DONE transition overrides the DRAIN one above
                    if (acc_v) begin
                        acc <= acc_sum;
                        m_r <= m_r + MW'(1);
                        if (last_acc) begin
                            y     <= acc_sum;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - scoreboard bench for mult_seq across several width/latency configurations
module tb_mult_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] start_v = '0;
    logic [2047:0] da = '0;
    logic [2047:0] db = '0;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    bit mon_on = 1'b0;
    int en_cnt [4];

    typedef struct {
        int id;
        logic [2047:0] a;
        logic [2047:0] b;
        logic [4095:0] y;
        longint t0;
    } op_t;
    op_t sbq [$];

    // instance 0: 8x8 on 4-bit digits, latency 1
    logic busy0, done0, en0;
    logic [15:0] y0;
    logic [3:0] ma0, mb0;
    logic [7:0] mp0;
    mult_seq #(.NBITS(8), .WBITS(4), .MUL_LAT(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(da[7:0]), .b(db[7:0]),
        .busy(busy0), .done(done0), .y(y0), .mul_en(en0), .mul_a(ma0), .mul_b(mb0), .mul_p(mp0));
    always @(posedge clk) mp0 <= en0 ? {4'b0, ma0} * {4'b0, mb0} : 8'($urandom);

    // instance 1: 16x16 on 4-bit digits, latency 3
    logic busy1, done1, en1;
    logic [31:0] y1;
    logic [3:0] ma1, mb1;
    logic [7:0] p1s [3];
    mult_seq #(.NBITS(16), .WBITS(4), .MUL_LAT(3)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(da[15:0]), .b(db[15:0]),
        .busy(busy1), .done(done1), .y(y1), .mul_en(en1), .mul_a(ma1), .mul_b(mb1), .mul_p(p1s[2]));
    always @(posedge clk) begin
        p1s[0] <= en1 ? {4'b0, ma1} * {4'b0, mb1} : 8'($urandom);
        p1s[1] <= p1s[0];
        p1s[2] <= p1s[1];
    end

    // instance 2: 8x8 on 4-bit digits, combinational multiplier
    logic busy2, done2, en2;
    logic [15:0] y2;
    logic [3:0] ma2, mb2;
    logic [7:0] junk2, mp2;
    mult_seq #(.NBITS(8), .WBITS(4), .MUL_LAT(0)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(da[7:0]), .b(db[7:0]),
        .busy(busy2), .done(done2), .y(y2), .mul_en(en2), .mul_a(ma2), .mul_b(mb2), .mul_p(mp2));
    always @(posedge clk) junk2 <= 8'($urandom);
    assign mp2 = en2 ? {4'b0, ma2} * {4'b0, mb2} : junk2;

    // instance 3: default parameters
    logic busy3, done3, en3;
    logic [4095:0] y3;
    logic [63:0] ma3, mb3;
    logic [127:0] mp3;
    mult_seq u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .a(da), .b(db),
        .busy(busy3), .done(done3), .y(y3), .mul_en(en3), .mul_a(ma3), .mul_b(mb3), .mul_p(mp3));
    always @(posedge clk) mp3 <= en3 ? {64'b0, ma3} * {64'b0, mb3} : {$urandom, $urandom, $urandom, $urandom};

    task automatic chk(input string name, input logic [4095:0] act, input logic [4095:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (low 256 bits)", name, act[255:0], exp[255:0]);
        end
    endtask

    // per-cycle monitor for one instance: digit stream, idle outputs, completion
    task automatic mon(input int id, input int k, input int w, input int lat,
                       input logic dn, input logic bz, input logic en,
                       input logic [63:0] ma, input logic [63:0] mb, input logic [4095:0] yv);
        logic [2047:0] sh;
        logic [63:0] msk;
        int n;
        msk = (64'(1) << w) - 64'(1);
        if (!bz) en_cnt[id] = 0;
        if (en) begin
            if (sbq.size() == 0 || sbq[0].id != id) begin
                chk($sformatf("u%0d_unexpected_issue", id), 4096'(1), 4096'(0));
            end else begin
                n = en_cnt[id];
                sh = sbq[0].a >> (w * (n / k));
                chk($sformatf("u%0d_mul_a[%0d]", id, n), 4096'(ma), 4096'(sh[63:0] & msk));
                sh = sbq[0].b >> (w * (n % k));
                chk($sformatf("u%0d_mul_b[%0d]", id, n), 4096'(mb), 4096'(sh[63:0] & msk));
                en_cnt[id]++;
            end
        end else begin
            chk($sformatf("u%0d_digits_idle", id), 4096'({ma, mb}), 4096'(0));
        end
        if (dn) begin
            if (sbq.size() == 0 || sbq[0].id != id) begin
                chk($sformatf("u%0d_unexpected_done", id), 4096'(1), 4096'(0));
            end else begin
                chk($sformatf("u%0d_y", id), yv, sbq[0].y);
                chk($sformatf("u%0d_latency", id), 4096'(cyc - sbq[0].t0), 4096'(k * k + lat));
                chk($sformatf("u%0d_issue_count", id), 4096'(en_cnt[id]), 4096'(k * k));
                chk($sformatf("u%0d_busy_at_done", id), 4096'(bz), 4096'(1));
                void'(sbq.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, 2, 4, 1, done0, busy0, en0, 64'(ma0), 64'(mb0), 4096'(y0));
            mon(1, 4, 4, 3, done1, busy1, en1, 64'(ma1), 64'(mb1), 4096'(y1));
            mon(2, 2, 4, 0, done2, busy2, en2, 64'(ma2), 64'(mb2), 4096'(y2));
            mon(3, 32, 64, 1, done3, busy3, en3, ma3, mb3, y3);
        end
    end

    function automatic logic [2047:0] rnd(input int nb);
        logic [2047:0] r;
        for (int k = 0; k < 64; k++) r[k*32 +: 32] = $urandom;
        if (nb < 2048) r = r & ((2048'(1) << nb) - 2048'(1));
        return r;
    endfunction

    function automatic logic [4095:0] prod(input logic [2047:0] av, input logic [2047:0] bv);
        return {2048'b0, av} * {2048'b0, bv};
    endfunction

    task automatic push_op(input int id, input logic [2047:0] av, input logic [2047:0] bv,
                           input logic [4095:0] ye);
        op_t e;
        e.id = id; e.a = av; e.b = bv; e.y = ye; e.t0 = cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 1200 && sbq.size() != 0; c++) @(negedge clk);
        if (sbq.size() != 0) begin
            chk({name, "_timeout"}, 4096'(sbq.size()), 4096'(0));
            sbq.delete();
        end
    endtask

    task automatic do_op(input int id, input int nb, input logic [2047:0] av,
                         input logic [2047:0] bv, input logic [4095:0] ye);
        @(negedge clk);
        da = av; db = bv; start_v[id] = 1'b1;
        @(posedge clk); #1;
        push_op(id, av, bv, ye);
        @(negedge clk);
        start_v[id] = 1'b0;
        da = rnd(nb); db = rnd(nb);
        wait_drain($sformatf("u%0d_op", id));
    endtask

    initial begin
        logic [2047:0] ra, rb;
        logic [2047:0] ones;
        logic [4095:0] big;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 4096'({busy0, busy1, busy2, busy3}), 4096'(0));
        chk("reset_done", 4096'({done0, done1, done2, done3}), 4096'(0));
        chk("reset_mul_en", 4096'({en0, en1, en2, en3}), 4096'(0));
        chk("reset_digits", 4096'({ma0, mb0, ma1, mb1, ma2, mb2, ma3, mb3}), 4096'(0));
        chk("reset_y_small", 4096'({y0, y1, y2}), 4096'(0));
        chk("reset_y_wide", y3, 4096'(0));
        mon_on = 1'b1;

        do_op(0, 8, 2048'hFF, 2048'hFF, 4096'h0000_FE01);
        do_op(1, 16, 2048'h1234, 2048'hABCD, 4096'h0C37_4FA4);
        do_op(2, 8, 2048'h00, 2048'h5A, 4096'h0);

        // start held high: each op accepted from IDLE, mid-op operand changes ignored
        @(negedge clk);
        da = 2048'd3; db = 2048'd5; start_v[0] = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk); #1;
            push_op(0, 2048'd3, 2048'd5, 4096'd15);
            if (r < 3) begin
                repeat (2 * 2 + 1 + 1) begin
                    @(negedge clk);
                    da = rnd(8); db = rnd(8);
                end
                @(negedge clk);
                da = 2048'd3; db = 2048'd5;
            end
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_drain("hold_start");

        // reset while issue n=2 is on the bus discards the op entirely
        @(negedge clk);
        da = 2048'hFF; db = 2048'hFF; start_v[0] = 1'b1;
        @(posedge clk); #1;
        push_op(0, 2048'hFF, 2048'hFF, 4096'h0000_FE01);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        sbq.delete();
        @(negedge clk);
        chk("abort_busy", 4096'(busy0), 4096'(0));
        chk("abort_y", 4096'(y0), 4096'(0));
        chk("abort_mul_en", 4096'(en0), 4096'(0));
        rst = 1'b0;
        do_op(0, 8, 2048'd2, 2048'd3, 4096'd6);

        for (int r = 0; r < 16; r++) begin
            ra = rnd(8); rb = rnd(8);
            do_op(0, 8, ra, rb, prod(ra, rb));
            ra = rnd(16); rb = rnd(16);
            do_op(1, 16, ra, rb, prod(ra, rb));
            ra = rnd(8); rb = rnd(8);
            do_op(2, 8, ra, rb, prod(ra, rb));
        end

        ones = '1;
        big = '1;
        big = big - (4096'(1) << 2049) + 4096'(2);
        do_op(3, 2048, ones, ones, big);
        for (int r = 0; r < 25; r++) begin
            ra = rnd(2048); rb = rnd(2048);
            if (r == 0) ra = '0;
            do_op(3, 2048, ra, rb, prod(ra, rb));
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
